mem_responder: RTL and testbench

- Memory-side responder for the multicycle RV32I core's memory port. It answers the datapath/control's read and write requests on mem_address / mem_wdata / mem_rdata.
- Holds a word-addressed storage array with per-byte write enables.
- Returns a single-cycle mem_resp after a programmable latency.
- Used as the core's memory in block-level and top-level benches; synthesizable for small FPGA builds.

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder_array.sv | 36 +++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states, captured op kinds,
// and the latency counter sizing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } mem_op_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Core memory-port bundle: request side driven by the core (master), completion side
// driven by the responder (slave).
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_rdata, mem_resp, mem_err
  );
endinterface

// File: rtl/mem_responder_array.sv
// Word-addressed storage with per-byte write enables, combinational read, and a
// synchronous clear of every word on rst.
module mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [3:0]            wmask_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core: captures a request, waits a fixed
// latency, then commits the write / loads read data and pulses mem_resp for one cycle.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; captures the request on arrival
// WAIT  | latency countdown; request inputs ignored
// RESP  | mem_resp (and mem_err if rejected) high for this one cycle
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  mem_io
);

  localparam int LAT_C = (LATENCY > MAX_LATENCY) ? MAX_LATENCY :
                         (LATENCY < 1)           ? 1 : LATENCY;

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  mem_op_t               op_q, op_d;
  logic                  oor_q, oor_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  enter_resp;
  logic                  arr_we;
  logic [31:0]           arr_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_io.mem_read || mem_io.mem_write) begin
          op_d    = (mem_io.mem_read && mem_io.mem_write) ? OP_BAD :
                    mem_io.mem_read ? OP_RD : OP_WR;
          oor_d   = |(mem_io.mem_address >> (ADDR_WIDTH + 2));
          idx_d   = mem_io.mem_address[ADDR_WIDTH+1:2];
          wmask_d = mem_io.mem_wmask;
          wdata_d = mem_io.mem_wdata;
          cnt_d   = CNT_W'(LAT_C - 1);
          state_d = (LAT_C == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The _d capture values equal _q outside IDLE, so they are valid on every RESP entry,
  // including the direct IDLE->RESP path when the latency is one cycle.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign arr_we     = enter_resp && (op_d == OP_WR) && !oor_d;

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && (op_d == OP_RD)) begin
      rdata_d = oor_d ? 32'h0 : arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .wmask_i (wmask_d),
    .waddr_i (idx_d),
    .wdata_i (wdata_d),
    .raddr_i (idx_d),
    .rdata_o (arr_rdata)
  );

  assign mem_io.mem_rdata = rdata_q;
  assign mem_io.mem_resp  = (state_q == RESP);
  assign mem_io.mem_err   = (state_q == RESP) && ((op_q == OP_BAD) || oor_q);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at latencies 3, 1 and 15 with hand-computed results.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mem_responder_if bus3 ();
  mem_responder_if bus1 ();
  mem_responder_if bus15 ();

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3))  dut3  (.clk(clk), .rst(rst), .mem_io(bus3));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1))  dut1  (.clk(clk), .rst(rst), .mem_io(bus1));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) dut15 (.clk(clk), .rst(rst), .mem_io(bus15));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Holds a request on bus3 until mem_resp, scrambling wdata/wmask after acceptance.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        output logic [31:0] rdata, output logic err, output int lat);
    int k;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    k     = 0;
    @(posedge clk); #1;
    bus3.mem_read    = rd;
    bus3.mem_write   = wr;
    bus3.mem_address = addr;
    bus3.mem_wdata   = wdata;
    bus3.mem_wmask   = wmask;
    while (lat < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        bus3.mem_wdata = ~wdata;
        bus3.mem_wmask = 4'hF;
      end
      if (bus3.mem_resp) begin
        lat   = k;
        rdata = bus3.mem_rdata;
        err   = bus3.mem_err;
      end
    end
    bus3.mem_read  = 1'b0;
    bus3.mem_write = 1'b0;
    if (lat < 0) check("timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(bus3.mem_resp), 32'd0);
    check("err_low_idle", 32'(bus3.mem_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [7:0]  pat;
    logic        saw;

    bus3.mem_read = 0;  bus3.mem_write = 0;  bus3.mem_wmask = 0;  bus3.mem_address = 0;  bus3.mem_wdata = 0;
    bus1.mem_read = 0;  bus1.mem_write = 0;  bus1.mem_wmask = 0;  bus1.mem_address = 0;  bus1.mem_wdata = 0;
    bus15.mem_read = 0; bus15.mem_write = 0; bus15.mem_wmask = 0; bus15.mem_address = 0; bus15.mem_wdata = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_resp", 32'(bus3.mem_resp), 32'd0);
    check("rst_err", 32'(bus3.mem_err), 32'd0);
    check("rst_rdata", bus3.mem_rdata, 32'h0);

    do_req(1, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check("rd_cleared", rd, 32'h0);

    // write then read, latency 3
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_err", 32'(err), 32'd0);
    check("wr_keeps_rdata", rd, 32'h0);
    do_req(1, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", 32'(err), 32'd0);

    // byte-lane merge
    do_req(0, 1, 32'h20, 32'h11223344, 4'hF, rd, err, lat);
    do_req(0, 1, 32'h22, 32'h00AA0000, 4'b0100, rd, err, lat);
    do_req(1, 0, 32'h20, 32'h0, 4'h0, rd, err, lat);
    check("merge", rd, 32'h11AA3344);
    do_req(0, 1, 32'h20, 32'h0, 4'h0, rd, err, lat);
    check("mask0_lat", 32'(lat), 32'd3);
    do_req(1, 0, 32'h20, 32'h0, 4'h0, rd, err, lat);
    check("mask0_keep", rd, 32'h11AA3344);

    // out of range (aliases word 0 if the range check were missing)
    do_req(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, rd, err, lat);
    do_req(0, 1, 32'h1000, 32'h12345678, 4'hF, rd, err, lat);
    check("oor_wr_err", 32'(err), 32'd1);
    check("oor_wr_lat", 32'(lat), 32'd3);
    do_req(1, 0, 32'h1000, 32'h0, 4'h0, rd, err, lat);
    check("oor_rd_err", 32'(err), 32'd1);
    check("oor_rd_data", rd, 32'h0);
    do_req(1, 0, 32'h0, 32'h0, 4'h0, rd, err, lat);
    check("oor_word0", rd, 32'hCAFEF00D);
    check("oor_word0_err", 32'(err), 32'd0);

    // read+write together
    do_req(1, 1, 32'h30, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    check("viol_err", 32'(err), 32'd1);
    check("viol_rdata_hold", rd, 32'hCAFEF00D);
    do_req(1, 0, 32'h30, 32'h0, 4'h0, rd, err, lat);
    check("viol_no_write", rd, 32'h0);

    // reset during WAIT
    do_req(1, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check("pre_rst_data", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus3.mem_write = 1; bus3.mem_address = 32'h40; bus3.mem_wdata = 32'h55; bus3.mem_wmask = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus3.mem_write = 0;
    saw = bus3.mem_resp;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus3.mem_resp) saw = 1'b1;
    end
    check("rst_mid_no_resp", 32'(saw), 32'd0);
    check("rst_mid_rdata", bus3.mem_rdata, 32'h0);
    do_req(1, 0, 32'h40, 32'h0, 4'h0, rd, err, lat);
    check("rst_mid_discard", rd, 32'h0);
    do_req(1, 0, 32'h10, 32'h0, 4'h0, rd, err, lat);
    check("rst_mid_cleared", rd, 32'h0);

    // latency 1, request held continuously
    @(posedge clk); #1;
    bus1.mem_read = 1; bus1.mem_address = 32'h0;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      pat[k] = bus1.mem_resp;
    end
    bus1.mem_read = 0;
    check("lat1_alternate", {24'd0, pat}, 32'h55);

    // latency 15
    @(posedge clk); #1;
    bus15.mem_write = 1; bus15.mem_address = 32'h4; bus15.mem_wdata = 32'hA5A5A5A5; bus15.mem_wmask = 4'hF;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus15.mem_resp) begin
        lat = k;
        err = bus15.mem_err;
      end
    end
    bus15.mem_write = 0;
    check("lat15", 32'(lat), 32'd15);
    check("lat15_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
